// File: rtl/uart_pkg.sv
// Shared types and widths for the UART boot loader: the RX and loader FSM state
// encodings plus the little-endian byte packing helper.
package uart_pkg;

    localparam int BYTE_WID = 8;
    localparam int DATA_WID = 32;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        L_LEN,
        L_DATA,
        L_DONE,
        L_HALT
    } ld_state_t;

    // Shift a new byte in at the top, so that the first byte of a group of four
    // ends up in bits [7:0].
    function automatic logic [DATA_WID-1:0] pack_byte(input logic [DATA_WID-1:0] acc,
                                                      input logic [BYTE_WID-1:0] b);
        return {b, acc[DATA_WID-1:BYTE_WID]};
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: a 2-FF synchronizer feeding a mid-bit sampling FSM.
// It emits one-cycle byte_valid or frame_err pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                rx_i,
    output logic                byte_valid_o,
    output logic [BYTE_WID-1:0] byte_data_o,
    output logic                frame_err_pulse_o
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t           state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          bit_q;
    logic [BYTE_WID-1:0] shreg_q;
    logic                rx_meta_q;
    logic                rx_s_q;
    logic                byte_valid_q;
    logic                ferr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            byte_valid_q <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            rx_meta_q    <= rx_i;
            rx_s_q       <= rx_meta_q;
            byte_valid_q <= 1'b0;
            ferr_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                // Re-check at mid start bit so short glitches are rejected.
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rx_s_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shreg_q <= {rx_s_q, shreg_q[BYTE_WID-1:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (rx_s_q) begin
                            byte_valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // shreg_q is stable from the stop sample until the next start bit's data phase.
    assign byte_valid_o      = byte_valid_q;
    assign byte_data_o       = shreg_q;
    assign frame_err_pulse_o = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a length-prefixed little-endian word image over UART and drives memory
// port B (uart_data/uart_addr) while holding the CPU in reset until uart_done.
module uart_boot_loader
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MAX_WORDS    = 16384
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                rx_i,
    input  logic                reload_i,
    output logic [DATA_WID-1:0] uart_data_o,
    output logic [31:0]         uart_addr_o,
    output logic                uart_done_o,
    output logic                frame_err_o,
    output logic                len_err_o
);

    logic                byte_valid;
    logic [BYTE_WID-1:0] byte_data;
    logic                ferr_pulse;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .rx_i             (rx_i),
        .byte_valid_o     (byte_valid),
        .byte_data_o      (byte_data),
        .frame_err_pulse_o(ferr_pulse)
    );

    ld_state_t           st_q;
    logic [1:0]          idx_q;
    logic [DATA_WID-1:0] asm_q;
    logic [31:0]         len_q;
    logic [31:0]         wcnt_q;
    logic [DATA_WID-1:0] data_q;
    logic [31:0]         addr_q;
    logic                done_q;
    logic                ferr_q;
    logic                lerr_q;

    logic [DATA_WID-1:0] asm_d;
    logic [31:0]         wcnt_d;
    logic                last_byte;
    logic                accepting;

    assign asm_d     = pack_byte(asm_q, byte_data);
    assign wcnt_d    = wcnt_q + 32'd1;
    assign last_byte = (idx_q == 2'd3);
    assign accepting = byte_valid && ((st_q == L_LEN) || (st_q == L_DATA));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            st_q   <= L_LEN;
            idx_q  <= '0;
            asm_q  <= '0;
            len_q  <= '0;
            wcnt_q <= '0;
            data_q <= '0;
            addr_q <= BASE_ADDR;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            // Done lags the final latch by one cycle so the last write lands first.
            done_q <= (st_q == L_DONE);
            if (ferr_pulse) begin
                ferr_q <= 1'b1;
            end
            // Reload wins over a byte arriving in the same cycle; the byte is lost.
            if (reload_i) begin
                st_q   <= L_LEN;
                idx_q  <= '0;
                asm_q  <= '0;
                wcnt_q <= '0;
                data_q <= '0;
                addr_q <= BASE_ADDR;
                done_q <= 1'b0;
                ferr_q <= 1'b0;
                lerr_q <= 1'b0;
            end else if (accepting) begin
                asm_q <= asm_d;
                idx_q <= idx_q + 2'd1;
                if (last_byte) begin
                    if (st_q == L_LEN) begin
                        len_q <= asm_d;
                        if (asm_d == '0) begin
                            st_q <= L_DONE;
                        end else if (asm_d > 32'(MAX_WORDS)) begin
                            lerr_q <= 1'b1;
                            st_q   <= L_HALT;
                        end else begin
                            st_q <= L_DATA;
                        end
                    end else begin
                        data_q <= asm_d;
                        addr_q <= BASE_ADDR + (wcnt_q << 2);
                        wcnt_q <= wcnt_d;
                        if (wcnt_d == len_q) begin
                            st_q <= L_DONE;
                        end
                    end
                end
            end
        end
    end

    assign uart_data_o = data_q;
    assign uart_addr_o = addr_q;
    assign uart_done_o = done_q;
    assign frame_err_o = ferr_q;
    assign len_err_o   = lerr_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: directed scenarios plus random images
// compared against a word-queue reference model.
module tb_uart_boot_loader;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        reload = 1'b0;
    logic [31:0] data;
    logic [31:0] addr;
    logic        done;
    logic        ferr;
    logic        lerr;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_chg = 0;
    int done_cyc = 0;
    int bv_cnt = 0;
    logic [63:0] prev_ad = '0;
    logic        prev_done = 1'b0;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (BASE),
        .MAX_WORDS   (MAXW)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .rx_i       (rx),
        .reload_i   (reload),
        .uart_data_o(data),
        .uart_addr_o(addr),
        .uart_done_o(done),
        .frame_err_o(ferr),
        .len_err_o  (lerr)
    );

    // Timestamps of output changes, and a count of accepted bytes.
    always @(negedge clk) begin
        cyc++;
        if ({addr, data} !== prev_ad) last_chg = cyc;
        if (done && !prev_done) done_cyc = cyc;
        prev_ad   = {addr, data};
        prev_done = done;
        if (dut.u_rx.byte_valid_o) bv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                            input logic edone);
        chk({tag, "_addr"}, addr, ea);
        chk({tag, "_data"}, data, ed);
        chk({tag, "_done"}, 32'(done), 32'(edone));
    endtask

    // One 8N1 frame; with rl set, reload is raised in the cycle the byte is consumed.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit rl);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        if (rl) begin
            chk("bv_align", 32'(dut.u_rx.byte_valid_o), 32'd1);
            reload = 1'b1;
            @(negedge clk);
            reload = 1'b0;
        end else begin
            @(negedge clk);
        end
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit rl_last);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, rl_last && (i == 3));
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] wq[$];
        logic [31:0] w;
        int n;
        int bv0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_outs("rst", BASE, 32'h0, 1'b0);
        chk("rst_ferr", 32'(ferr), 32'd0);
        chk("rst_lerr", 32'(lerr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: two-word image
        send_word(32'd2, 1'b0);
        chk_outs("t1_hdr", BASE, 32'h0, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        chk_outs("t1_w0", BASE, 32'h1234_5678, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        chk_outs("t1_w1", BASE + 32'd4, 32'hDEAD_BEEF, 1'b1);
        chk("t1_done_lat", 32'(done_cyc - last_chg), 32'd1);
        send_byte(8'hA5, 1'b1, 1'b0);
        chk_outs("t1_ignore", BASE + 32'd4, 32'hDEAD_BEEF, 1'b1);

        // 2: empty image
        pulse_reload();
        chk_outs("t2_rl", BASE, 32'h0, 1'b0);
        send_word(32'd0, 1'b0);
        chk_outs("t2_empty", BASE, 32'h0, 1'b1);

        // 3: oversize header halts until reload
        pulse_reload();
        send_word(32'd5, 1'b0);
        chk("t3_lerr", 32'(lerr), 32'd1);
        send_word(32'd1, 1'b0);
        send_word(32'h0BAD_F00D, 1'b0);
        chk_outs("t3_halt", BASE, 32'h0, 1'b0);
        chk("t3_lerr_hold", 32'(lerr), 32'd1);
        pulse_reload();
        chk("t3_lerr_clr", 32'(lerr), 32'd0);
        send_word(32'd1, 1'b0);
        send_word(32'hCAFE_0001, 1'b0);
        chk_outs("t3_load", BASE, 32'hCAFE_0001, 1'b1);

        // 4: framing error drops the byte
        pulse_reload();
        send_byte(8'h03, 1'b0, 1'b0);
        chk("t4_ferr", 32'(ferr), 32'd1);
        send_word(32'd1, 1'b0);
        send_word(32'h5566_7788, 1'b0);
        chk_outs("t4_load", BASE, 32'h5566_7788, 1'b1);

        // 5: one-cycle start glitch
        bv0 = bv_cnt;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_no_byte", 32'(bv_cnt - bv0), 32'd0);
        chk("t5_idle", 32'(dut.u_rx.state_q), 32'(uart_pkg::IDLE));

        // 6a: reload coincident with a word's last byte
        pulse_reload();
        chk("t6_ferr_clr", 32'(ferr), 32'd0);
        send_word(32'd1, 1'b0);
        send_word(32'h1111_2222, 1'b1);
        chk_outs("t6_rl_drop", BASE, 32'h0, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'h3333_4444, 1'b0);
        chk_outs("t6_after_rl", BASE, 32'h3333_4444, 1'b1);

        // 6b: reset in the middle of a word
        pulse_reload();
        send_word(32'd2, 1'b0);
        send_word(32'hAAAA_5555, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_outs("t6_rst", BASE, 32'h0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_word(32'd1, 1'b0);
        send_word(32'h7777_8888, 1'b0);
        chk_outs("t6_after_rst", BASE, 32'h7777_8888, 1'b1);

        // Random images against the word-queue model
        for (int t = 0; t < 6; t++) begin
            pulse_reload();
            n = int'($urandom_range(1, MAXW));
            wq.delete();
            send_word(32'(n), 1'b0);
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                wq.push_back(w);
                send_word(w, 1'b0);
                chk_outs("rnd", BASE + 32'(4 * k), wq[k], k == n - 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
